fifo_wr_arbiter: RTL

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

---
 rtl/fifo_wr_arbiter.sv | 135 +++++++++++++
 1 files changed

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one FIFO write port among NREQ
// requesters. Optional per-requester stats: FIFO_WR_ARB_STATS_EN.
//
// Ports:
//   wr_clk, rst_n        clock, async active-low reset
//   req_valid/req_data   per-requester beat and data (i at [i*DW +: DW])
//   req_ready            beat of requester i accepted this cycle
//   fifo_full            FIFO full flag (write domain)
//   fifo_wr_en/fifo_din  FIFO write port
//   grant, busy          one-hot owner, high while bursting
//   beat_cnt             (FIFO_WR_ARB_STATS_EN only) 16-bit sat counts
module fifo_wr_arbiter #(
  parameter int NREQ  = 4,
  parameter int DW    = 8,
  parameter int BURST = 4
) (
  input  logic               wr_clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*DW-1:0] req_data,
  output logic [NREQ-1:0]    req_ready,
  input  logic               fifo_full,
  output logic               fifo_wr_en,
  output logic [DW-1:0]      fifo_din,
  output logic [NREQ-1:0]    grant,
  output logic               busy
`ifdef FIFO_WR_ARB_STATS_EN
  ,
  output logic [NREQ*16-1:0] beat_cnt
`endif
);

  localparam int OW = $clog2(NREQ);
  localparam int CW = $clog2(BURST + 1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_BURST = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [OW-1:0]   r_owner;
  logic [OW-1:0]   w_owner_nxt;
  logic [OW-1:0]   w_rr;
  logic            w_found;
  logic [CW-1:0]   r_cnt;
  logic [CW-1:0]   w_cnt_nxt;
  logic [CW-1:0]   w_cnt_inc;

  assign w_cnt_inc = r_cnt + 1'b1;

  // r_owner doubles as last_owner: it is loaded on burst entry and
  // held through IDLE, so the search starts one past it.
  always_comb begin
    w_rr    = r_owner;
    w_found = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!w_found && req_valid[(int'(r_owner) + k) % NREQ]) begin
        w_rr    = OW'((int'(r_owner) + k) % NREQ);
        w_found = 1'b1;
      end
    end
  end

  always_ff @(posedge wr_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_owner <= OW'(NREQ - 1);
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_owner <= w_owner_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_cnt_nxt   = r_cnt;
    req_ready   = '0;
    fifo_wr_en  = 1'b0;
    fifo_din    = '0;
    grant       = '0;
    busy        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (|req_valid) begin
          w_state_nxt = S_BURST;
          w_owner_nxt = w_rr;
          w_cnt_nxt   = '0;
        end
      end
      S_BURST: begin
        busy             = 1'b1;
        grant[r_owner]   = 1'b1;
        req_ready[r_owner] = !fifo_full;
        fifo_wr_en       = req_valid[r_owner] && !fifo_full;
        for (int i = 0; i < NREQ; i++) begin
          if (r_owner == OW'(i)) begin
            fifo_din = req_data[i*DW +: DW];
          end
        end
        // A dropped valid ends the burst even while the FIFO is full.
        if (!req_valid[r_owner]) begin
          w_state_nxt = S_IDLE;
        end else if (!fifo_full) begin
          w_cnt_nxt = w_cnt_inc;
          if (w_cnt_inc == CW'(BURST)) begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

`ifdef FIFO_WR_ARB_STATS_EN
  logic [NREQ-1:0][15:0] r_stat;

  always_ff @(posedge wr_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stat <= '0;
    end else if (fifo_wr_en && r_stat[r_owner] != 16'hFFFF) begin
      r_stat[r_owner] <= r_stat[r_owner] + 16'd1;
    end
  end

  assign beat_cnt = r_stat;
`else
  // statistics counters not built
`endif

endmodule
